lsu_mem_master: RTL and testbench

- Load/store initiator in the MEM stage of the RV64I pipeline. It drives the byte-addressed data memory port: rden, 8-bit wren byte mask, rdaddress/wraddress and write_data, and receives read_data.
- It accepts one load or store request at a time from the pipeline over a valid/ready handshake.
- It issues the memory access, then returns the sign- or zero-extended load result, or a store acknowledge, over a valid/ready response channel.
- It flags out-of-range and illegal-size accesses without touching memory.

---
 rtl/lsu_mem_master.sv | 179 +++++++++++++++++
 tb/tb_lsu_mem_master.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// +--------------------------------------------------------------------------+
// | lsu_mem_master : MEM-stage load/store initiator for a byte-addressed     |
// | data memory. Optional macro: LSU_MISALIGN_TRAP_EN. Rev 1.0               |
// +--------------------------------------------------------------------------+
`default_nettype none

module lsu_mem_master #(
   parameter int     ADDR_W    = 16,
   parameter longint MEM_BYTES = 65536
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_funct3,
   input  logic [63:0]       req_addr,
   input  logic [63:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [63:0]       rsp_data,
   output logic              rsp_err,
   output logic              rden,
   output logic [7:0]        wren,
   output logic [ADDR_W-1:0] rdaddress,
   output logic [ADDR_W-1:0] wraddress,
   output logic [63:0]       write_data,
   input  logic [63:0]       read_data
);

   localparam logic [64:0] LAST_BYTE = 65'(MEM_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t              state_q;
   logic                store_q;
   logic                err_q;
   logic [2:0]          funct3_q;
   logic                req_ready_q;
   logic                rsp_valid_q;
   logic [63:0]         rsp_data_q;
   logic                rsp_err_q;
   logic                rden_q;
   logic [7:0]          wren_q;
   logic [ADDR_W-1:0]   rdaddress_q;
   logic [ADDR_W-1:0]   wraddress_q;
   logic [63:0]         write_data_q;

   logic [3:0]          size_m1;
   logic [7:0]          mask_d;
   logic [63:0]         write_data_d;
   logic [63:0]         rsp_data_d;
   logic                f3_ok;
   logic                range_ok;
   logic                align_ok;
   logic                legal_d;

   // End address is formed at 65 bits so an access near 2^64 cannot wrap into range.
   always_comb begin
      size_m1      = 4'd0;
      mask_d       = 8'h01;
      write_data_d = '0;
      align_ok     = 1'b1;
      case (req_funct3[1:0])
         2'b00: begin size_m1 = 4'd0; mask_d = 8'h01; end
         2'b01: begin size_m1 = 4'd1; mask_d = 8'h03; end
         2'b10: begin size_m1 = 4'd3; mask_d = 8'h0F; end
         default: begin size_m1 = 4'd7; mask_d = 8'hFF; end
      endcase
      for (int i = 0; i < 8; i++) begin
         write_data_d[8*i +: 8] = mask_d[i] ? req_wdata[8*i +: 8] : 8'h00;
      end
      f3_ok    = req_store ? ~req_funct3[2] : (req_funct3 != 3'b111);
      range_ok = ({1'b0, req_addr} + {61'b0, size_m1}) <= LAST_BYTE;
`ifdef LSU_MISALIGN_TRAP_EN
      case (req_funct3[1:0])
         2'b01:   align_ok = ~req_addr[0];
         2'b10:   align_ok = (req_addr[1:0] == 2'b00);
         2'b11:   align_ok = (req_addr[2:0] == 3'b000);
         default: align_ok = 1'b1;
      endcase
`endif
      legal_d = f3_ok & range_ok & align_ok;
   end

   always_comb begin
      rsp_data_d = '0;
      case (funct3_q)
         3'b000:  rsp_data_d = {{56{read_data[7]}},  read_data[7:0]};
         3'b001:  rsp_data_d = {{48{read_data[15]}}, read_data[15:0]};
         3'b010:  rsp_data_d = {{32{read_data[31]}}, read_data[31:0]};
         3'b011:  rsp_data_d = read_data;
         3'b100:  rsp_data_d = {56'b0, read_data[7:0]};
         3'b101:  rsp_data_d = {48'b0, read_data[15:0]};
         3'b110:  rsp_data_d = {32'b0, read_data[31:0]};
         default: rsp_data_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         store_q      <= 1'b0;
         err_q        <= 1'b0;
         funct3_q     <= 3'b000;
         req_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
         rden_q       <= 1'b0;
         wren_q       <= 8'h00;
         rdaddress_q  <= '0;
         wraddress_q  <= '0;
         write_data_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  store_q     <= req_store;
                  funct3_q    <= req_funct3;
                  err_q       <= ~legal_d;
                  req_ready_q <= 1'b0;
                  rsp_data_q  <= '0;
                  rsp_err_q   <= ~legal_d;
                  rden_q      <= legal_d & ~req_store;
                  wren_q      <= (legal_d & req_store) ? mask_d : 8'h00;
                  if (legal_d && !req_store) begin
                     rdaddress_q <= req_addr[ADDR_W-1:0];
                  end
                  if (legal_d && req_store) begin
                     wraddress_q  <= req_addr[ADDR_W-1:0];
                     write_data_q <= write_data_d;
                  end
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               rden_q      <= 1'b0;
               wren_q      <= 8'h00;
               rsp_valid_q <= 1'b1;
               rsp_data_q  <= (!err_q && !store_q) ? rsp_data_d : 64'd0;
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  rsp_err_q   <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
               rden_q      <= 1'b0;
               wren_q      <= 8'h00;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_err    = rsp_err_q;
   assign rden       = rden_q;
   assign wren       = wren_q;
   assign rdaddress  = rdaddress_q;
   assign wraddress  = wraddress_q;
   assign write_data = write_data_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
// +--------------------------------------------------------------------------+
// | tb_lsu_mem_master : directed self-checking bench with a byte memory      |
// | model. Honours LSU_MISALIGN_TRAP_EN. Rev 1.0                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_lsu_mem_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_data;
   logic        rsp_err;
   logic        rden;
   logic [7:0]  wren;
   logic [15:0] rdaddress;
   logic [15:0] wraddress;
   logic [63:0] write_data;
   logic [63:0] read_data;

   logic [7:0]  mem [0:65535];

   int checks   = 0;
   int failures = 0;

   logic        acc_rden;
   logic [7:0]  acc_wren;
   logic [15:0] acc_rdaddr;
   logic [15:0] acc_wraddr;
   logic [63:0] acc_wdata;
   logic [63:0] res_data;
   logic        res_err;
   logic [63:0] hold_data;

   always #5 clk = ~clk;

   lsu_mem_master #(.ADDR_W(16), .MEM_BYTES(65536)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_store  (req_store),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .rden       (rden),
      .wren       (wren),
      .rdaddress  (rdaddress),
      .wraddress  (wraddress),
      .write_data (write_data),
      .read_data  (read_data)
   );

   // Memory writes are not reset-gated, matching the real array.
   always @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (wren[i]) mem[wraddress + 16'(i)] <= write_data[8*i +: 8];
      end
   end

   always_comb begin
      read_data = '0;
      if (rden) begin
         for (int i = 0; i < 8; i++) read_data[8*i +: 8] = mem[rdaddress + 16'(i)];
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic accept(input logic st, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
      @(negedge clk);
      req_valid  = 1'b1;
      req_store  = st;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      check("req_ready_idle", {63'b0, req_ready}, 64'd1);
      @(posedge clk); #1;
      req_valid  = 1'b0;
      acc_rden   = rden;
      acc_wren   = wren;
      acc_rdaddr = rdaddress;
      acc_wraddr = wraddress;
      acc_wdata  = write_data;
      check("rsp_valid_in_access", {63'b0, rsp_valid}, 64'd0);
   endtask

   task automatic to_resp();
      int n = 0;
      @(posedge clk); #1;
      check("rsp_latency", {63'b0, rsp_valid}, 64'd1);
      while (!rsp_valid && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      if (!rsp_valid) begin
         checks++;
         failures++;
         $error("FAIL rsp_timeout observed=0 expected=1");
      end
      check("no_rden_in_resp", {56'b0, wren, 7'b0, rden}, 64'd0);
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("hs_rsp_valid", {63'b0, rsp_valid}, 64'd0);
      check("hs_req_ready", {63'b0, req_ready}, 64'd1);
   endtask

   task automatic do_op(input logic st, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
      accept(st, f3, a, wd);
      to_resp();
      res_data = rsp_data;
      res_err  = rsp_err;
      handshake();
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
      req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", {63'b0, req_ready}, 64'd1);
      check("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
      check("rst_rden_wren", {55'b0, rden, wren}, 64'd0);
      check("rst_rsp_data",  rsp_data, 64'd0);
      check("rst_rsp_err",   {63'b0, rsp_err}, 64'd0);
      check("rst_addrs",     {32'b0, rdaddress, wraddress}, 64'd0);
      rst = 1'b0;

      // SD / LD round trip
      do_op(1'b1, 3'b011, 64'h0100, 64'h1122334455667788);
      check("sd_wren",   {56'b0, acc_wren}, 64'hFF);
      check("sd_rden",   {63'b0, acc_rden}, 64'd0);
      check("sd_wdata",  acc_wdata, 64'h1122334455667788);
      check("sd_waddr",  {48'b0, acc_wraddr}, 64'h0100);
      check("sd_data",   res_data, 64'd0);
      check("sd_err",    {63'b0, res_err}, 64'd0);
      do_op(1'b0, 3'b011, 64'h0100, 64'd0);
      check("ld_rden",   {63'b0, acc_rden}, 64'd1);
      check("ld_wren",   {56'b0, acc_wren}, 64'd0);
      check("ld_raddr",  {48'b0, acc_rdaddr}, 64'h0100);
      check("ld_data",   res_data, 64'h1122334455667788);
      check("ld_err",    {63'b0, res_err}, 64'd0);

      // SB with upper bytes masked, then LB / LBU
      do_op(1'b1, 3'b000, 64'h0200, 64'hFFFF_FFFF_FFFF_FF80);
      check("sb_wren",   {56'b0, acc_wren}, 64'h01);
      check("sb_wdata",  acc_wdata, 64'h80);
      do_op(1'b0, 3'b000, 64'h0200, 64'd0);
      check("lb_data",   res_data, 64'hFFFF_FFFF_FFFF_FF80);
      do_op(1'b0, 3'b100, 64'h0200, 64'd0);
      check("lbu_data",  res_data, 64'h80);

      // SW, LW, LWU, SH, LHU
      do_op(1'b1, 3'b010, 64'h0300, 64'hDEAD_BEEF_8000_0001);
      check("sw_wren",   {56'b0, acc_wren}, 64'h0F);
      check("sw_wdata",  acc_wdata, 64'h8000_0001);
      do_op(1'b0, 3'b010, 64'h0300, 64'd0);
      check("lw_data",   res_data, 64'hFFFF_FFFF_8000_0001);
      do_op(1'b0, 3'b110, 64'h0300, 64'd0);
      check("lwu_data",  res_data, 64'h0000_0000_8000_0001);
      do_op(1'b1, 3'b001, 64'h0300, 64'h1234_ABCD);
      check("sh_wren",   {56'b0, acc_wren}, 64'h03);
      check("sh_wdata",  acc_wdata, 64'hABCD);
      do_op(1'b0, 3'b101, 64'h0300, 64'd0);
      check("lhu_data",  res_data, 64'hABCD);
      do_op(1'b0, 3'b001, 64'h0300, 64'd0);
      check("lh_data",   res_data, 64'hFFFF_FFFF_FFFF_ABCD);

      // Range and size legality
      do_op(1'b0, 3'b011, 64'hFFFC, 64'd0);
      check("oor_ld_err",  {63'b0, res_err}, 64'd1);
      check("oor_ld_rden", {63'b0, acc_rden}, 64'd0);
      check("oor_ld_data", res_data, 64'd0);
      do_op(1'b0, 3'b011, 64'hFFF8, 64'd0);
      check("edge_ld_err", {63'b0, res_err}, 64'd0);
      check("edge_ld_rden", {63'b0, acc_rden}, 64'd1);
      do_op(1'b0, 3'b000, 64'h1_0000, 64'd0);
      check("oor_lb_err",  {63'b0, res_err}, 64'd1);
      do_op(1'b0, 3'b011, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0);
      check("wrap_ld_err", {63'b0, res_err}, 64'd1);
      check("wrap_ld_rden", {63'b0, acc_rden}, 64'd0);
      do_op(1'b1, 3'b100, 64'h0500, 64'h55);
      check("st100_err",   {63'b0, res_err}, 64'd1);
      check("st100_wren",  {56'b0, acc_wren}, 64'd0);
      do_op(1'b0, 3'b111, 64'h0500, 64'd0);
      check("ld111_err",   {63'b0, res_err}, 64'd1);
      check("ld111_rden",  {63'b0, acc_rden}, 64'd0);

      // Backpressure: word at 0x300 is now 0x8000ABCD
      accept(1'b0, 3'b010, 64'h0300, 64'd0);
      to_resp();
      hold_data = 64'hFFFF_FFFF_8000_ABCD;
      check("bp_data0", rsp_data, hold_data);
      req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b000; req_addr = 64'h0200;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("bp_valid", {63'b0, rsp_valid}, 64'd1);
         check("bp_data",  rsp_data, hold_data);
         check("bp_err",   {63'b0, rsp_err}, 64'd0);
         check("bp_ready", {63'b0, req_ready}, 64'd0);
         check("bp_rden",  {63'b0, rden}, 64'd0);
      end
      req_valid = 1'b0;
      handshake();
      do_op(1'b0, 3'b000, 64'h0200, 64'd0);
      check("after_bp_lb", res_data, 64'hFFFF_FFFF_FFFF_FF80);

      // Reset while in RESP drops the response
      accept(1'b0, 3'b000, 64'h0200, 64'd0);
      to_resp();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_resp_valid", {63'b0, rsp_valid}, 64'd0);
      check("rst_resp_ready", {63'b0, req_ready}, 64'd1);
      check("rst_resp_err",   {63'b0, rsp_err}, 64'd0);

      // Reset while in ACCESS: the store still lands in memory
      accept(1'b1, 3'b000, 64'h0400, 64'h5A);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_acc_wren",  {56'b0, wren}, 64'd0);
      check("rst_acc_valid", {63'b0, rsp_valid}, 64'd0);
      check("rst_acc_ready", {63'b0, req_ready}, 64'd1);
      do_op(1'b0, 3'b100, 64'h0400, 64'd0);
      check("rst_acc_lbu",   res_data, 64'h5A);

      // Misaligned word load: bytes 0x102..0x105 are 66 55 44 33
      do_op(1'b0, 3'b010, 64'h0102, 64'd0);
`ifdef LSU_MISALIGN_TRAP_EN
      check("mis_lw_err",  {63'b0, res_err}, 64'd1);
      check("mis_lw_rden", {63'b0, acc_rden}, 64'd0);
      check("mis_lw_data", res_data, 64'd0);
`else
      check("mis_lw_err",  {63'b0, res_err}, 64'd0);
      check("mis_lw_rden", {63'b0, acc_rden}, 64'd1);
      check("mis_lw_data", res_data, 64'h0000_0000_3344_5566);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
